// File: rtl/calc_rr_scheduler.sv
// calc_rr_scheduler: round-robin sharing of one calculator over a press/done handshake,
// with timeout abort and tagged, registered responses.
module calc_rr_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [4*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    input  logic [3*NREQ-1:0] req_op,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [1:0]        rsp_id,
    output logic [7:0]        rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [3:0]        calc_a,
    output logic [3:0]        calc_b,
    output logic [2:0]        calc_op,
    output logic              calc_press,
    input  logic [7:0]        calc_result,
    input  logic              calc_done
);
    typedef enum logic [1:0] {IDLE, WAIT_DONE, RELEASE, RESPOND} state_t;
    state_t          state, state_n;
    logic [1:0]      ptr, ptr_n, gnt, gnt_n, pick, idx;
    logic            hit, err, err_n, expired;
    logic [7:0]      cnt, cnt_n, res, res_n;
    logic [NREQ-1:0] req_ready_n;
    logic            rsp_valid_n, rsp_err_n, calc_press_n, busy_n;
    logic [1:0]      rsp_id_n;
    logic [7:0]      rsp_data_n;
    logic [3:0]      calc_a_n, calc_b_n;
    logic [2:0]      calc_op_n;
    logic [3:0]      a_arr [NREQ];
    logic [3:0]      b_arr [NREQ];
    logic [2:0]      op_arr [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i]  = req_a[4*i +: 4];
            b_arr[i]  = req_b[4*i +: 4];
            op_arr[i] = req_op[3*i +: 3];
        end
    end

    // Scan downward from the farthest slot so the first valid at/after ptr wins.
    always_comb begin
        hit  = 1'b0;
        pick = '0;
        idx  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = 2'((int'(ptr) + k) % NREQ);
            if (req_valid[idx]) begin
                hit  = 1'b1;
                pick = idx;
            end
        end
    end

    assign expired = cnt == 8'(TIMEOUT - 1);

    always_comb begin
        state_n      = state;
        ptr_n        = ptr;
        gnt_n        = gnt;
        cnt_n        = cnt + 8'd1;
        err_n        = err;
        res_n        = res;
        calc_a_n     = calc_a;
        calc_b_n     = calc_b;
        calc_op_n    = calc_op;
        calc_press_n = calc_press;
        req_ready_n  = '0;
        rsp_valid_n  = 1'b0;
        rsp_id_n     = '0;
        rsp_data_n   = '0;
        rsp_err_n    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (hit) begin
                    state_n      = WAIT_DONE;
                    gnt_n        = pick;
                    err_n        = 1'b0;
                    res_n        = '0;
                    calc_a_n     = a_arr[pick];
                    calc_b_n     = b_arr[pick];
                    calc_op_n    = op_arr[pick];
                    calc_press_n = 1'b1;
                    req_ready_n  = NREQ'(1) << pick;
                end
            end
            WAIT_DONE: if (calc_done || expired) begin
                state_n      = RELEASE;
                cnt_n        = '0;
                calc_press_n = 1'b0;
                err_n        = !calc_done;
                res_n        = calc_done ? calc_result : 8'd0;
            end
            RELEASE: if (!calc_done || expired) begin
                state_n     = RESPOND;
                rsp_valid_n = 1'b1;
                rsp_id_n    = gnt;
                rsp_err_n   = err | calc_done;
                rsp_data_n  = (err | calc_done) ? 8'd0 : res;
            end
            default: begin
                state_n = IDLE;
                ptr_n   = (int'(gnt) == NREQ - 1) ? 2'd0 : gnt + 2'd1;
            end
        endcase
        busy_n = state_n != IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            gnt        <= '0;
            cnt        <= '0;
            err        <= 1'b0;
            res        <= '0;
            calc_a     <= '0;
            calc_b     <= '0;
            calc_op    <= '0;
            calc_press <= 1'b0;
            req_ready  <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            gnt        <= gnt_n;
            cnt        <= cnt_n;
            err        <= err_n;
            res        <= res_n;
            calc_a     <= calc_a_n;
            calc_b     <= calc_b_n;
            calc_op    <= calc_op_n;
            calc_press <= calc_press_n;
            req_ready  <= req_ready_n;
            rsp_valid  <= rsp_valid_n;
            rsp_id     <= rsp_id_n;
            rsp_data   <= rsp_data_n;
            rsp_err    <= rsp_err_n;
            busy       <= busy_n;
        end
    end
endmodule
